// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a stable-level debouncer.
// The accepted level only changes after the synchronized input has differed
// from it for CYCLES consecutive clock edges. Any bounce back restarts the count.
// 'rise' pulses on the same edge where 'level' goes 0->1.
module debouncer #(
    parameter int CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic sync1;
    logic sync2;
    logic [CNT_W-1:0] cnt;

    // Bring the raw asynchronous input into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    // Count consecutive cycles of disagreement and accept the new level on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign rise = sync2 && !level && (cnt == CNT_LAST);

endmodule

// File: rtl/input_queue.sv
// Operator input queue: a debounced key press captures the synchronized
// switches into a first-word-fall-through FIFO that the CPU drains with rd.
module input_queue #(
    parameter int IN_WIDTH        = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       key_n,
    input  logic [IN_WIDTH-1:0]        sw,
    input  logic                       rd,
    output logic [DATA_WIDTH-1:0]      out,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                  key_pressed;
    logic                  key_level;
    logic                  press;
    logic [IN_WIDTH-1:0]   sw_sync1;
    logic [IN_WIDTH-1:0]   sw_s;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_ptr_next;
    logic [CNT_W-1:0]      count_next;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] head_next;
    logic                  pop;
    logic                  push;

    assign key_pressed = ~key_n;

    debouncer #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk  (clk),
        .rst  (rst),
        .in   (key_pressed),
        .level(key_level),
        .rise (press)
    );

    // Synchronize the switches so the captured value is never metastable.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_sync1 <= '0;
            sw_s     <= '0;
        end else begin
            sw_sync1 <= sw;
            sw_s     <= sw_sync1;
        end
    end

    // Decide push/pop and work out the head the FIFO will present after this edge.
    always_comb begin
        pop         = rd && valid;
        push        = press && (!full || pop);
        write_data  = DATA_WIDTH'(sw_s);
        rd_ptr_next = rd_ptr + PTR_W'(pop);
        count_next  = count + CNT_W'(push) - CNT_W'(pop);
        head_next   = '0;
        if (count_next != '0) begin
            if (push && (wr_ptr == rd_ptr_next)) begin
                head_next = write_data;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    // Storage array; contents need no reset because count guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= write_data;
        end
    end

    // Pointers, occupancy, registered head and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            out    <= head_next;
            if (press && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign valid = (count != '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: doc/input_queue.md
# input_queue

Debounced operator-input queue feeding the CPU's `in` port; counterpart of the CPU→LED output path. A debounced press of the input key captures the switch value into a small FIFO. The head entry is presented to the CPU with a valid/read handshake, so CPU `IN` instructions consume one operator entry each instead of sampling live switches.

## Interface
- `IN_WIDTH`, 4: switch bits captured per entry.
- `DATA_WIDTH`, 16: output word width; entries are zero-extended from `IN_WIDTH`.
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥ 2.
- `DEBOUNCE_CYCLES`, 500_000: consecutive stable cycles needed to accept a key level change; must be ≥ 2.

- `clk`  in  1: single clock for the whole block.
- `rst`  in  1: synchronous, active-high reset.
- `key_n`  in  1: raw push-button, active-low, asynchronous to `clk`.
- `sw`  in  IN_WIDTH: raw switches, asynchronous.
- `rd`  in  1: CPU pop request; acts only when `valid` = 1.
- `out`  out  DATA_WIDTH: head entry, zero-extended; 0 when empty.
- `valid`  out  1: FIFO non-empty.
- `full`  out  1: count == DEPTH.
- `count`  out  $clog2(DEPTH)+1: number of stored entries.
- `overflow`  out  1: sticky; set when a press is dropped because the FIFO is full.

## Operation
- `key_n` and `sw` each pass through a two-flop synchronizer. The key is inverted, giving `key_s` (1 = pressed).
- Debouncer holds a level `db` and a counter `cnt`:
  - If `key_s` == `db`, `cnt` is cleared.
  - Otherwise `cnt` increments.
  - On the edge where `cnt` == DEBOUNCE_CYCLES-1 and `key_s` still differs, `db` takes `key_s` and `cnt` clears.
  - Any bounce back to `db` restarts the count.
- A press event is a single-cycle pulse on the same edge where `db` goes 0→1. Release (1→0) produces no event.
- Push on a press event:
  - Write `{0, sw_s}` at the write pointer and advance it.
  - If `full` and no pop occurs on that edge, drop the entry and set `overflow`.
- Pop on an edge with `rd` = 1 and `valid` = 1: the read pointer advances. `rd` while empty is ignored.
- FIFO is first-word-fall-through: `out` is the registered head value, updated on the same edge as any push or pop.
- Push and pop on the same edge:
  - When full: both happen, `count` stays DEPTH, `overflow` is not set.
  - When empty: only the push happens; `count` becomes 1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately to distinguish full from empty.
- Reset values: `db`=0, `cnt`=0, synchronizers=0 (pressed-side key sync resets to released), pointers=0, `count`=0, `out`=0, `valid`=0, `full`=0, `overflow`=0.
- Reset asserted mid-debounce or with a non-empty FIFO discards all state. A key held through reset release must be stable for DEBOUNCE_CYCLES before it registers as a press.

## Timing
- Let edge 1 be the first edge that samples a new `key_n` level.
  - `key_s` is updated after edge 2.
  - `db` updates and the push happens at edge DEBOUNCE_CYCLES+2.
  - `valid` and `out` are visible after that edge.
- The captured switch value is `sw_s` at the push edge, i.e. `sw` as it was two edges earlier.
- Pop latency is one edge: with `rd` high before edge k, the new head or `valid`=0 is visible after edge k.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Sub-module `debouncer` (parameter `CYCLES`; ports `clk`, `rst`, `in`, `level`, `rise`). It contains the synchronizer and counter, and is reusable for the other buttons.
- Counter width is $clog2(DEBOUNCE_CYCLES) as a localparam. Pointer and count widths are localparams of `input_queue`.
- No shared package is needed: there are no typedefs, and all constants derive from parameters.
- RAM is an inferred register array. No memory initialization file is used.

## Test plan
- DEBOUNCE_CYCLES=4, `sw`=4'hA, hold `key_n` low → `valid` rises after edge 6, `out`=16'h000A, `count`=1.
- Bounce `key_n` low 3 cycles, high 1, low 3, high (DEBOUNCE_CYCLES=4) → no push, `count`=0, `valid`=0.
- Push values 1..8 (DEPTH=8), then a 9th press → `full`=1, `overflow`=1, `count`=8. Popping with `rd` yields 1..8 in order, then `valid`=0 and `out`=0.
- FIFO full, press event coinciding with `rd` → `count` stays 8, `overflow` stays 0, new value becomes the tail.
- Empty FIFO, press coinciding with `rd` → `count`=1, `out` = the pushed value.
- Assert `rst` for one cycle with 3 entries stored and the key mid-debounce → all outputs return to reset values, and the held key produces a push only DEBOUNCE_CYCLES+2 edges after `rst` drops.
